// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the instruction/data SRAM bus arbiter.
// State codes and access-size codes are fixed so other blocks can decode them.
package sram_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_ADDR = 3'd1,
    ARB_D_DATA = 3'd2,
    ARB_I_ADDR = 3'd3,
    ARB_I_DATA = 3'd4
  } arb_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Loads never assert byte strobes on the bus.
  function automatic logic [3:0] store_strobe(input logic we, input logic [3:0] sel);
    return we ? sel : 4'b0000;
  endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and data access, data first,
// one transaction at a time; returned words are held until the pipeline advances.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_instr,
  output logic          stallreq_from_if,
  input  logic          mem_en,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [3:0]    sel,
  input  logic [1:0]    mem_size,
  output logic [DW-1:0] mem_rdata,
  output logic          stallreq_from_mem,
  input  logic          pipe_stall,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [3:0]    bus_wstrb,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  arb_state_t    state_reg, state_next;
  logic          i_done_reg, i_done_next;
  logic          d_done_reg, d_done_next;
  logic [AW-1:0] i_addr_reg, i_addr_next;
  logic [DW-1:0] i_rdata_reg, i_rdata_next;
  logic [DW-1:0] d_rdata_reg, d_rdata_next;
  logic          d_pend, i_pend;
  logic          i_set, d_set;

  assign d_pend = mem_en & ~d_done_reg;
  assign i_pend = ~i_done_reg;

  assign stallreq_from_if  = i_pend;
  assign stallreq_from_mem = d_pend;
  assign if_instr          = i_rdata_reg;
  assign mem_rdata         = d_rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ARB_IDLE;
      i_done_reg  <= 1'b0;
      d_done_reg  <= 1'b0;
      i_addr_reg  <= '0;
      i_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      i_done_reg  <= i_done_next;
      d_done_reg  <= d_done_next;
      i_addr_reg  <= i_addr_next;
      i_rdata_reg <= i_rdata_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    i_addr_next  = i_addr_reg;
    i_rdata_next = i_rdata_reg;
    d_rdata_next = d_rdata_reg;
    i_set        = 1'b0;
    d_set        = 1'b0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = SIZE_W;
    bus_wstrb    = 4'b0000;
    bus_addr     = i_addr_reg;
    bus_wdata    = '0;

    case (state_reg)
      ARB_IDLE: begin
        if (d_pend) begin
          state_next = ARB_D_ADDR;
        end else if (i_pend) begin
          state_next  = ARB_I_ADDR;
          i_addr_next = if_pc;
        end
      end
      ARB_D_ADDR: begin
        bus_req   = 1'b1;
        bus_wr    = mem_we;
        bus_size  = mem_size;
        bus_wstrb = store_strobe(mem_we, sel);
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        if (bus_addr_ok) begin
          state_next = ARB_D_DATA;
        end
      end
      ARB_D_DATA: begin
        // Fields stay on the bus for slaves that sample them in the data phase.
        bus_wr    = mem_we;
        bus_size  = mem_size;
        bus_wstrb = store_strobe(mem_we, sel);
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        if (bus_data_ok) begin
          d_set      = 1'b1;
          state_next = ARB_IDLE;
          if (!mem_we) begin
            d_rdata_next = bus_rdata;
          end
        end
      end
      ARB_I_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) begin
          state_next = ARB_I_DATA;
        end
      end
      ARB_I_DATA: begin
        if (bus_data_ok) begin
          state_next = ARB_IDLE;
          // A PC redirect during the fetch makes the returned word stale.
          if (i_addr_reg == if_pc) begin
            i_set        = 1'b1;
            i_rdata_next = bus_rdata;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase

    // Done flags survive stalls and drop once the pipeline advances.
    i_done_next = i_set | (i_done_reg & pipe_stall);
    d_done_next = d_set | (d_done_reg & pipe_stall);
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed-vector bench for sram_bus_arbiter with a scoreboarded bus slave model.
// Expected bus transactions, fetched words and load words are queued at issue time.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stallreq_from_if;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  sel;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        stallreq_from_mem;
  logic        pipe_stall;
  logic        ext_stall;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  sram_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_instr(if_instr), .stallreq_from_if(stallreq_from_if),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sel(sel), .mem_size(mem_size), .mem_rdata(mem_rdata),
    .stallreq_from_mem(stallreq_from_mem), .pipe_stall(pipe_stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pipe_stall = stallreq_from_if | stallreq_from_mem | ext_stall;

  // ---------------- bus slave model with programmable wait states ----------------
  localparam int NM = 10;
  localparam logic [31:0] M_ADDR [NM] = '{
    32'hBFC00000, 32'hBFC00004, 32'h80001000, 32'hBFC00008, 32'h80001004,
    32'hBFC0000C, 32'h80000010, 32'hBFC00380, 32'hBFC00010, 32'h80001008};
  localparam logic [31:0] M_INIT [NM] = '{
    32'h24080001, 32'h24090002, 32'h12345678, 32'h3C1D8000, 32'h11111111,
    32'h8C880004, 32'hAAAA5555, 32'h401A6800, 32'h27BDFFF0, 32'hCAFEF00D};

  logic [31:0] m_data [NM];
  int          addr_wait = 0;
  int          data_wait = 0;
  logic        s_data;
  int          s_cnt;
  int          s_idx;
  logic        s_wr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_strb;
  int          acc_idx;

  function automatic int find_idx(input logic [31:0] a);
    int r;
    r = -1;
    for (int k = 0; k < NM; k++)
      if (M_ADDR[k] == {a[31:2], 2'b00}) r = k;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  assign acc_idx     = find_idx(bus_addr);
  assign bus_addr_ok = bus_req && !s_data && (s_cnt >= addr_wait);
  assign bus_data_ok = s_data && (s_cnt >= data_wait);
  assign bus_rdata   = s_data ? s_rdata : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_data  <= 1'b0;
      s_cnt   <= 0;
      s_idx   <= -1;
      s_wr    <= 1'b0;
      s_wdata <= 32'h0;
      s_rdata <= 32'h0;
      s_strb  <= 4'h0;
      for (int k = 0; k < NM; k++) m_data[k] <= M_INIT[k];
    end else if (!s_data) begin
      if (bus_req && bus_addr_ok) begin
        s_data  <= 1'b1;
        s_cnt   <= 0;
        s_idx   <= acc_idx;
        s_wr    <= bus_wr;
        s_wdata <= bus_wdata;
        s_strb  <= bus_wstrb;
        s_rdata <= (acc_idx >= 0) ? m_data[acc_idx[3:0]] : 32'hDEADBEEF;
      end else if (bus_req) begin
        s_cnt <= s_cnt + 1;
      end else begin
        s_cnt <= 0;
      end
    end else begin
      if (bus_data_ok) begin
        s_data <= 1'b0;
        s_cnt  <= 0;
        if (s_wr && s_idx >= 0)
          m_data[s_idx[3:0]] <= merge(m_data[s_idx[3:0]], s_wdata, s_strb);
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    exp_bus   [$];
  logic [31:0] exp_instr [$];
  logic [31:0] exp_load  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  task automatic check_bus();
    bus_exp_t e;
    if (exp_bus.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL bus_unexpected: got transaction at %08h, required none", bus_addr);
    end else begin
      e = exp_bus.pop_front();
      $display("bus txn: addr=%08h wr=%0d size=%0d strb=%b wdata=%08h",
               bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata);
      check("bus_addr", bus_addr, e.addr);
      check("bus_wr", 32'(bus_wr), 32'(e.wr));
      check("bus_size", 32'(bus_size), 32'(e.size));
      check("bus_wstrb", 32'(bus_wstrb), 32'(e.strb));
      if (e.wr) check("bus_wdata", bus_wdata, e.wdata);
    end
  endtask

  task automatic check_instr();
    logic [31:0] e;
    if (exp_instr.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_unexpected: got completion with %08h, required none", if_instr);
    end else begin
      e = exp_instr.pop_front();
      $display("fetch done: if_pc=%08h if_instr=%08h", if_pc, if_instr);
      check("if_instr", if_instr, e);
    end
  endtask

  task automatic check_load();
    logic [31:0] e;
    if (exp_load.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_unexpected: got completion with %08h, required none", mem_rdata);
    end else begin
      e = exp_load.pop_front();
      $display("load done: mem_addr=%08h mem_rdata=%08h", mem_addr, mem_rdata);
      check("mem_rdata", mem_rdata, e);
    end
  endtask

  logic prev_if_stall  = 1'b1;
  logic prev_mem_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_if_stall  <= 1'b1;
      prev_mem_stall <= 1'b0;
    end else begin
      if (bus_req && bus_addr_ok) check_bus();
      if (prev_if_stall && !stallreq_from_if) check_instr();
      if (prev_mem_stall && !stallreq_from_mem && mem_en && !mem_we) check_load();
      prev_if_stall  <= stallreq_from_if;
      prev_mem_stall <= stallreq_from_mem;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [1:0]  size;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
    int          aw;
    int          dw;
  } vec_t;

  vec_t vecs [7];

  task automatic apply(input int i);
    vec_t v;
    v = vecs[i];
    if_pc     = v.pc;
    mem_en    = v.en;
    mem_we    = v.we;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    sel       = v.sel;
    mem_size  = v.size;
    addr_wait = v.aw;
    data_wait = v.dw;
    if (v.en) begin
      exp_bus.push_back('{wr: v.we, size: v.size, strb: (v.we ? v.sel : 4'b0000),
                          addr: v.addr, wdata: v.wdata});
      if (!v.we) exp_load.push_back(v.exp_rdata);
    end
    exp_bus.push_back('{wr: 1'b0, size: SIZE_W, strb: 4'b0000, addr: v.pc, wdata: 32'h0});
    exp_instr.push_back(v.exp_instr);
    $display("vector %0d: pc=%08h mem_en=%0d we=%0d addr=%08h", i, v.pc, v.en, v.we, v.addr);
  endtask

  // Wait for the pipeline to be unstalled, then cross the edge where it advances.
  task automatic advance();
    int k;
    k = 0;
    while (pipe_stall && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("advance", 32'(!pipe_stall), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input bit data_phase, input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = data_phase ? bus_data_ok : (bus_req & bus_addr_ok);
    end
    check(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    //          pc            en    we    addr          wdata         sel      size    instr         rdata         aw dw
    vecs[0] = '{32'hBFC00000, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, SIZE_W, 32'h24080001, 32'h0,        0, 0};
    vecs[1] = '{32'hBFC00004, 1'b1, 1'b0, 32'h80001000, 32'h0,        4'b1111, SIZE_W, 32'h24090002, 32'h12345678, 0, 0};
    vecs[2] = '{32'hBFC00008, 1'b1, 1'b1, 32'h80001006, 32'h00AB0000, 4'b0100, SIZE_B, 32'h3C1D8000, 32'h0,        0, 0};
    vecs[3] = '{32'hBFC0000C, 1'b1, 1'b0, 32'h80001004, 32'h0,        4'b0011, SIZE_H, 32'h8C880004, 32'h11AB1111, 1, 1};
    vecs[4] = '{32'hBFC00010, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, SIZE_W, 32'h27BDFFF0, 32'h0,        0, 0};
    vecs[5] = '{32'h80000010, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, SIZE_W, 32'h401A6800, 32'h0,        0, 2};
    vecs[6] = '{32'hBFC00004, 1'b1, 1'b0, 32'h80001008, 32'h0,        4'b1111, SIZE_W, 32'h24090002, 32'hCAFEF00D, 0, 3};

    rst       = 1'b1;
    ext_stall = 1'b0;
    apply(0);
    #3;
    check("rst_stall_if", 32'(stallreq_from_if), 32'd1);
    check("rst_stall_mem", 32'(stallreq_from_mem), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait fetch: IDLE, ADDR, DATA, then released in cycle 3.
    @(negedge clk);
    check("c0_bus_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    check("c1_bus_req", 32'(bus_req), 32'd1);
    check("c1_bus_addr", bus_addr, 32'hBFC00000);
    @(negedge clk);
    check("c2_bus_req", 32'(bus_req), 32'd0);
    check("c2_stall_if", 32'(stallreq_from_if), 32'd1);
    @(negedge clk);
    check("c3_stall_if", 32'(stallreq_from_if), 32'd0);
    check("c3_if_instr", if_instr, 32'h24080001);
    advance();

    // Load with pending fetch, byte store, half load reading back the merged word.
    for (int i = 1; i <= 3; i++) begin
      apply(i);
      advance();
    end

    // Pipeline stall holding a completed fetch.
    apply(4);
    ext_stall = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = !stallreq_from_if;
    end
    check("stall_fetch_done", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_if_instr", if_instr, 32'h27BDFFF0);
      check("stall_bus_req", 32'(bus_req), 32'd0);
      check("stall_flag_held", 32'(stallreq_from_if), 32'd0);
    end
    @(posedge clk);
    #1 ext_stall = 1'b0;
    advance();
    check("stall_flag_cleared", 32'(stallreq_from_if), 32'd1);

    // PC redirect while the fetch is in its data phase.
    apply(5);
    exp_bus.push_back('{wr: 1'b0, size: SIZE_W, strb: 4'b0000, addr: 32'hBFC00380, wdata: 32'h0});
    wait_bus(1'b0, "redirect_addr_phase");
    @(posedge clk);
    #1 if_pc = 32'hBFC00380;
    wait_bus(1'b1, "redirect_data_phase");
    @(negedge clk);
    check("redirect_stall_if", 32'(stallreq_from_if), 32'd1);
    check("redirect_instr_held", if_instr, 32'h27BDFFF0);
    advance();

    // Reset in the middle of a data read.
    apply(6);
    wait_bus(1'b0, "reset_addr_phase");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check("rst_mid_state", 32'(dut.state_reg), 32'(ARB_IDLE));
    check("rst_mid_mem_rdata", mem_rdata, 32'h0);
    check("rst_mid_if_instr", if_instr, 32'h0);
    check("rst_mid_stall_mem", 32'(stallreq_from_mem), 32'd1);
    exp_bus.delete();
    exp_instr.delete();
    exp_load.delete();
    mem_en    = 1'b0;
    addr_wait = 0;
    data_wait = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_bus.push_back('{wr: 1'b0, size: SIZE_W, strb: 4'b0000, addr: 32'hBFC00004, wdata: 32'h0});
    exp_instr.push_back(32'h24090002);
    advance();
    rst = 1'b1;

    #2;
    check("exp_bus_drained", 32'(exp_bus.size()), 32'd0);
    check("exp_instr_drained", 32'(exp_instr.size()), 32'd0);
    check("exp_load_drained", 32'(exp_load.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Arbiter that shares one SRAM-like memory bus between the pipeline's instruction-fetch port (`if_pc`/`if_instr`) and data port (`mem_en`/`mem_we`/`sel`/`mem_size`/`mem_rdata`). It sequences one bus transaction at a time, with data over instruction priority. It drives `stallreq_from_if` / `stallreq_from_mem` into the datapath's hazard unit and holds returned words stable across pipeline stalls.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `clk` in 1: clock; everything sampled on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `if_pc` in AW: fetch address, valid every cycle out of reset.
- `if_instr` out DW: fetched word, held.
- `stallreq_from_if` out 1: fetch not yet satisfied.
- `mem_en`, `mem_we` in 1: data access request, write enable.
- `mem_addr` in AW: data address (ALU result).
- `mem_wdata` in DW: store data, already lane-shifted.
- `sel` in 4: byte strobes.
- `mem_size` in 2: 0 byte, 1 half, 2 word.
- `mem_rdata` out DW: load word, held.
- `stallreq_from_mem` out 1: data access not yet satisfied.
- `pipe_stall` in 1: OR of all stage stalls; while high, the pipeline holds all requests stable.
- `bus_req`, `bus_wr` out 1: bus request, write.
- `bus_size` out 2: access size.
- `bus_wstrb` out 4: byte strobes.
- `bus_addr` out AW: bus address.
- `bus_wdata` out DW: bus write data.
- `bus_addr_ok` in 1: address phase accepted.
- `bus_data_ok` in 1: data phase complete.
- `bus_rdata` in DW: read data, valid with `bus_data_ok`.

## Operation
- FSM states: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
- `d_pend = mem_en & ~d_done`. `i_pend = ~i_done`.
- IDLE:
  - If `d_pend`, go to D_ADDR.
  - Else if `i_pend`, go to I_ADDR and latch `i_addr_q <= if_pc`.
- D_ADDR:
  - `bus_req=1`; bus fields come from the data port, with `bus_wstrb = mem_we ? sel : 4'b0`.
  - Stay until `bus_addr_ok`, then go to D_DATA.
- D_DATA:
  - `bus_req=0`.
  - On `bus_data_ok`: if read, `d_rdata_q <= bus_rdata`; set `d_done`; go to IDLE.
- I_ADDR:
  - `bus_req=1`, `bus_wr=0`, `bus_size=2`, `bus_addr=i_addr_q`.
  - On `bus_addr_ok`, go to I_DATA.
- I_DATA:
  - On `bus_data_ok`: if `i_addr_q == if_pc`, set `i_done` and `i_rdata_q <= bus_rdata`. Otherwise the PC was redirected by an exception or branch: discard the word and leave `i_done` clear.
  - Go to IDLE.
- An issued address phase is never withdrawn. A data request arriving during I_ADDR/I_DATA waits for that fetch to finish.
- `stallreq_from_if = i_pend`. `stallreq_from_mem = d_pend`.
- `if_instr = i_rdata_q`. `mem_rdata = d_rdata_q`.
- Completion flags:
  - `i_done` and `d_done` clear on any cycle with `pipe_stall==0` that does not itself set them, i.e. the pipeline has advanced.
  - Set wins over clear in the same cycle.

## Timing
- Reset values:
  - State IDLE; `i_done=0`, `d_done=0`.
  - `i_addr_q`, `i_rdata_q`, `d_rdata_q` = 0.
  - Therefore `stallreq_from_if=1`, `stallreq_from_mem=0`, `bus_req=0`, `if_instr=0`, `mem_rdata=0`.
- Minimum latency with zero-wait bus (`addr_ok` in the first request cycle, `data_ok` on the next):
  - 3 cycles from request to stall-release: IDLE, ADDR, DATA.
  - Each stall output falls combinationally in the cycle after `bus_data_ok` is sampled.
- Bus requirement: `bus_data_ok` never comes in the same cycle as `bus_addr_ok` for the same transaction.
- A fetch and a data access both pending in IDLE: the data access goes first; the fetch issues in the cycle after the data access completes.
- `rst` asserted mid-transaction: FSM and flags clear immediately. The bus slave must be reset by the same `rst`.
- Between requests, `if_pc` and `mem_addr` change only when `pipe_stall==0`.

## Structure
- Shared package entries:
  - State encoding constants: `ARB_IDLE`=0, `ARB_D_ADDR`=1, `ARB_D_DATA`=2, `ARB_I_ADDR`=3, `ARB_I_DATA`=4.
  - Size codes `SIZE_B`/`SIZE_H`/`SIZE_W`, added to `defines.h`.
- One flat module, no sub-modules.
- The datapath instance connects `mem_addr` to its `mem_wdata` (ALU result) and `mem_wdata` to `mem_wdata_last`.

## Test plan
- Reset, then `if_pc=0xBFC00000` with zero-wait bus returning `0x24080001` → `bus_addr=0xBFC00000` in cycle 1; `stallreq_from_if` low and `if_instr=0x24080001` from cycle 3.
- `mem_en=1`, `mem_we=0`, `mem_addr=0x80001000` in the same IDLE cycle as a pending fetch → data is issued first with `bus_wr=0`, `bus_size=2`; the fetch issues afterwards; `mem_rdata` holds `0x12345678`.
- Store: `mem_we=1`, `sel=4'b0100`, `mem_size=0`, `mem_wdata=0x00AB0000` → `bus_wr=1`, `bus_wstrb=4'b0100`; `stallreq_from_mem` clears after `data_ok`.
- `pipe_stall` held high for 5 cycles after fetch completion → `if_instr` stable, no new `bus_req`; the flag clears on the first cycle `pipe_stall=0`.
- `if_pc` changes from `0x80000010` to `0xBFC00380` during I_DATA → returned word discarded, `stallreq_from_if` stays high, refetch issued at `0xBFC00380`.
- `rst` pulsed during D_DATA → `bus_req=0` and state IDLE in the same cycle, `mem_rdata=0`.
